// File: rtl/rover_motor_sequencer.sv
// rover_motor_sequencer
//   Avalon-MM slave that turns software direction/duty commands into safe
//   H-bridge driver signals for the two rover sides. It provides PWM gating of
//   the enables, a forced dead-time between two non-coast directions, and a
//   watchdog that coasts both motors when software stops refreshing CMD.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select (0 CMD, 1 DUTY, 2 CTRL, 3 STATUS)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data (zero wait states)
//   out_port   registered {L_en, L_in2, L_in1, R_en, R_in2, R_in1}
module rover_motor_sequencer #(
  parameter int PRESCALE = 4,
  parameter int DEADTIME = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [5:0]  out_port
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // The dead counter is loaded with DEADTIME-1 so that out_port is held at
  // 000 for exactly DEADTIME edges before the new direction is applied.
  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);
  localparam logic [DT_W-1:0] DT_ZERO = DT_W'(0);

  localparam logic [1:0] ST_COAST = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  localparam logic [1:0] DIR_COAST = 2'b00;

  logic            wr_s, wr_cmd_s, wr_duty_s, wr_ctrl_s, wr_stat_s;
  logic [PS_W-1:0] presc_r;
  logic [7:0]      pwm_cnt_r;
  logic            presc_wrap_s, period_tick_s;
  logic [3:0]      cmd_r;
  logic [15:0]     duty_r;
  logic            enable_r, wdog_en_r, tripped_r;
  logic [15:0]     wdog_reload_r, wdog_cnt_r;
  logic            trip_s, cmd_acc_s, wdog_rise_s;
  logic [1:0]      r_st_r, l_st_r, r_app_r, l_app_r;
  logic [DT_W-1:0] r_cnt_r, l_cnt_r;
  logic [1:0]      r_st_s, l_st_s, r_app_s, l_app_s;
  logic [DT_W-1:0] r_cnt_s, l_cnt_s;
  logic            r_pwm_s, l_pwm_s;
  logic [5:0]      out_nxt_s;
  logic            unused_s;

  // Next {state, app_dir, dead_cnt} for one side.
  function automatic logic [DT_W+3:0] side_next(
    input logic            en,
    input logic [1:0]      st,
    input logic [1:0]      app,
    input logic [1:0]      tgt,
    input logic [DT_W-1:0] cnt
  );
    logic [1:0]      st_n;
    logic [1:0]      app_n;
    logic [DT_W-1:0] cnt_n;
    st_n  = st;
    app_n = app;
    cnt_n = cnt;
    if (!en) begin
      st_n  = ST_COAST;
      app_n = DIR_COAST;
      cnt_n = DT_ZERO;
    end else begin
      case (st)
        ST_COAST: begin
          if (tgt != DIR_COAST) begin
            app_n = tgt;
            st_n  = ST_DRIVE;
          end else begin
            app_n = DIR_COAST;
            st_n  = ST_COAST;
          end
        end
        ST_DRIVE: begin
          if (tgt == app) begin
            st_n = ST_DRIVE;
          end else if (tgt == DIR_COAST) begin
            app_n = DIR_COAST;
            st_n  = ST_COAST;
          end else begin
            cnt_n = DT_LOAD;
            app_n = DIR_COAST;
            st_n  = ST_DEAD;
          end
        end
        ST_DEAD: begin
          // The counter is never reloaded here, so writes during DEAD only
          // change which direction is applied when it expires.
          if (cnt == DT_ZERO) begin
            app_n = tgt;
            st_n  = (tgt == DIR_COAST) ? ST_COAST : ST_DRIVE;
          end else begin
            cnt_n = cnt - DT_W'(1);
          end
        end
        default: begin
          st_n  = ST_COAST;
          app_n = DIR_COAST;
          cnt_n = DT_ZERO;
        end
      endcase
    end
    return {st_n, app_n, cnt_n};
  endfunction

  // Driver pins {en, in2, in1} for an applied direction.
  function automatic logic [2:0] map_side(input logic [1:0] dir, input logic pwm_on);
    logic [2:0] pins;
    case (dir)
      2'b00:   pins = 3'b000;
      2'b01:   pins = {pwm_on, 2'b01};
      2'b10:   pins = {pwm_on, 2'b10};
      2'b11:   pins = 3'b111;
      default: pins = 3'b000;
    endcase
    return pins;
  endfunction

  assign unused_s = ^writedata[31:24];

  // Bus decode, PWM compare and watchdog event qualification.
  always_comb begin
    wr_s          = chipselect & ~write_n;
    wr_cmd_s      = wr_s & (address == 2'd0);
    wr_duty_s     = wr_s & (address == 2'd1);
    wr_ctrl_s     = wr_s & (address == 2'd2);
    wr_stat_s     = wr_s & (address == 2'd3);
    presc_wrap_s  = (presc_r == PS_LAST);
    period_tick_s = presc_wrap_s & (pwm_cnt_r == 8'hFF);
    trip_s        = period_tick_s & wdog_en_r & (wdog_cnt_r == 16'd0);
    // A trip on the same edge discards the write, and it does not reload.
    cmd_acc_s     = wr_cmd_s & ~tripped_r & ~trip_s;
    wdog_rise_s   = wr_ctrl_s & writedata[1] & ~wdog_en_r;
    r_pwm_s       = (pwm_cnt_r < duty_r[7:0]);
    l_pwm_s       = (pwm_cnt_r < duty_r[15:8]);
  end

  // Side state machines and the pins they will drive after this edge.
  always_comb begin
    {r_st_s, r_app_s, r_cnt_s} = side_next(enable_r, r_st_r, r_app_r, cmd_r[1:0], r_cnt_r);
    {l_st_s, l_app_s, l_cnt_s} = side_next(enable_r, l_st_r, l_app_r, cmd_r[3:2], l_cnt_r);
    out_nxt_s = {map_side(l_app_s, l_pwm_s), map_side(r_app_s, r_pwm_s)};
  end

  // Register readback mux.
  always_comb begin
    case (address)
      2'd0:    readdata = {28'd0, cmd_r};
      2'd1:    readdata = {16'd0, duty_r};
      2'd2:    readdata = {8'd0, wdog_reload_r, 6'd0, wdog_en_r, enable_r};
      2'd3:    readdata = {29'd0, (l_st_r == ST_DEAD), (r_st_r == ST_DEAD), tripped_r};
      default: readdata = 32'd0;
    endcase
  end

  // Free-running prescaler and 8-bit PWM count.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r   <= {PS_W{1'b0}};
      pwm_cnt_r <= 8'd0;
    end else if (presc_wrap_s) begin
      presc_r   <= {PS_W{1'b0}};
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end else begin
      presc_r   <= presc_r + PS_W'(1);
    end
  end

  // Software-visible registers and the trip flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r         <= 4'd0;
      duty_r        <= 16'd0;
      enable_r      <= 1'b0;
      wdog_en_r     <= 1'b0;
      wdog_reload_r <= 16'd0;
      tripped_r     <= 1'b0;
    end else begin
      if (trip_s) begin
        cmd_r <= 4'd0;
      end else if (cmd_acc_s) begin
        cmd_r <= writedata[3:0];
      end
      if (wr_duty_s) begin
        duty_r <= writedata[15:0];
      end
      if (wr_ctrl_s) begin
        enable_r      <= writedata[0];
        wdog_en_r     <= writedata[1];
        wdog_reload_r <= writedata[23:8];
      end
      // A trip outranks a simultaneous clear.
      if (trip_s) begin
        tripped_r <= 1'b1;
      end else if (wr_stat_s && writedata[0]) begin
        tripped_r <= 1'b0;
      end
    end
  end

  // Watchdog countdown in PWM periods.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_r <= 16'd0;
    end else if (wdog_rise_s) begin
      wdog_cnt_r <= writedata[23:8];
    end else if (cmd_acc_s) begin
      wdog_cnt_r <= wdog_reload_r;
    end else if (period_tick_s && wdog_en_r && (wdog_cnt_r != 16'd0)) begin
      wdog_cnt_r <= wdog_cnt_r - 16'd1;
    end
  end

  // Side state registers and the registered driver output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_r   <= ST_COAST;
      l_st_r   <= ST_COAST;
      r_app_r  <= DIR_COAST;
      l_app_r  <= DIR_COAST;
      r_cnt_r  <= DT_ZERO;
      l_cnt_r  <= DT_ZERO;
      out_port <= 6'd0;
    end else begin
      r_st_r   <= r_st_s;
      l_st_r   <= l_st_s;
      r_app_r  <= r_app_s;
      l_app_r  <= l_app_s;
      r_cnt_r  <= r_cnt_s;
      l_cnt_r  <= l_cnt_s;
      out_port <= out_nxt_s;
    end
  end

endmodule

// File: tb/tb_rover_motor_sequencer.sv
// Directed self-checking bench for rover_motor_sequencer.
module tb_rover_motor_sequencer;

  localparam int PRESCALE = 4;
  localparam int DEADTIME = 64;
  localparam int PERIOD   = 256 * PRESCALE;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [5:0]  out_port;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  rover_motor_sequencer #(.PRESCALE(PRESCALE), .DEADTIME(DEADTIME)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Edges since reset release; period ticks land on multiples of PERIOD.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    tick(3);
    n_cmp++; if (out_port !== 6'd0) begin n_err++; $display("FAIL reset_out: got %b want 000000", out_port); end
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_rd0: got %h want 0", readdata); end
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h want 0", readdata); end
    reset = 1'b0;
  endtask

  task automatic test_pwm;
    int hi_l, hi_r, bad;
    wr(2'd2, 32'h1); wr(2'd1, 32'h8080); wr(2'd0, 32'h5);
    tick(2);
    hi_l = 0; hi_r = 0; bad = 0;
    repeat (PERIOD) begin
      tick(1);
      if (out_port[5]) hi_l++;
      if (out_port[2]) hi_r++;
      if (out_port[4:3] !== 2'b01 || out_port[1:0] !== 2'b01) bad++;
    end
    n_cmp++; if (hi_l != 512) begin n_err++; $display("FAIL pwm_l_high: got %0d want 512", hi_l); end
    n_cmp++; if (hi_r != 512) begin n_err++; $display("FAIL pwm_r_high: got %0d want 512", hi_r); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL pwm_in_pins: got %0d bad cycles want 0", bad); end
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h5) begin n_err++; $display("FAIL cmd_readback: got %h want 5", readdata); end
  endtask

  task automatic test_deadtime;
    int bad_out, bad_st, hi_r;
    wr(2'd0, 32'h6);
    address = 2'd3;
    bad_out = 0; bad_st = 0;
    repeat (DEADTIME) begin
      tick(1);
      if (out_port[2:0] !== 3'b000) bad_out++;
      if (readdata[1] !== 1'b1) bad_st++;
    end
    n_cmp++; if (bad_out != 0) begin n_err++; $display("FAIL dead_out: got %0d non-zero cycles want 0", bad_out); end
    n_cmp++; if (bad_st != 0) begin n_err++; $display("FAIL dead_status: got %0d cycles without R_dead want 0", bad_st); end
    tick(1);
    n_cmp++; if (out_port[1:0] !== 2'b10) begin n_err++; $display("FAIL dead_exit_dir: got %b want 10", out_port[1:0]); end
    n_cmp++; if (readdata[1] !== 1'b0) begin n_err++; $display("FAIL dead_exit_status: got %b want 0", readdata[1]); end
    hi_r = 0;
    repeat (PERIOD) begin
      tick(1);
      if (out_port[2]) hi_r++;
    end
    n_cmp++; if (hi_r != 512) begin n_err++; $display("FAIL dead_pwm_r: got %0d want 512", hi_r); end
  endtask

  task automatic test_coast_then_reverse;
    wr(2'd0, 32'h4); tick(1);
    n_cmp++; if (out_port[2:0] !== 3'b000) begin n_err++; $display("FAIL coast_from_rev: got %b want 000", out_port[2:0]); end
    wr(2'd0, 32'h5); tick(1);
    n_cmp++; if (out_port[1:0] !== 2'b01) begin n_err++; $display("FAIL coast_to_fwd: got %b want 01", out_port[1:0]); end
    wr(2'd0, 32'h4); wr(2'd0, 32'h6);
    n_cmp++; if (out_port[2:0] !== 3'b000) begin n_err++; $display("FAIL coast_mid: got %b want 000", out_port[2:0]); end
    address = 2'd3; #1;
    n_cmp++; if (readdata[1] !== 1'b0) begin n_err++; $display("FAIL coast_no_dead: got %b want 0", readdata[1]); end
    tick(1);
    n_cmp++; if (out_port[1:0] !== 2'b10) begin n_err++; $display("FAIL coast_to_rev: got %b want 10", out_port[1:0]); end
  endtask

  task automatic test_brake;
    int bad;
    wr(2'd1, 32'h0); wr(2'd0, 32'h0); wr(2'd0, 32'hF);
    tick(2);
    bad = 0;
    repeat (300) begin
      tick(1);
      if (out_port !== 6'b111111) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL brake_const: got %0d bad cycles want 0", bad); end
    wr(2'd2, 32'h0); tick(1);
    n_cmp++; if (out_port !== 6'd0) begin n_err++; $display("FAIL disable_out: got %b want 000000", out_port); end
  endtask

  task automatic test_watchdog;
    int t;
    wr(2'd2, 32'h303);
    t = (cyc / PERIOD + 4) * PERIOD;
    wait_until(t - 1);
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL wdog_pre_status: got %h want 0", readdata); end
    n_cmp++; if (out_port !== 6'b111111) begin n_err++; $display("FAIL wdog_pre_out: got %b want 111111", out_port); end
    tick(1);
    n_cmp++; if (readdata !== 32'h1) begin n_err++; $display("FAIL wdog_trip_status: got %h want 1", readdata); end
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL wdog_trip_cmd: got %h want 0", readdata); end
    tick(1);
    n_cmp++; if (out_port !== 6'd0) begin n_err++; $display("FAIL wdog_trip_out: got %b want 000000", out_port); end
    wr(2'd0, 32'h5);
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL wdog_cmd_ignored: got %h want 0", readdata); end
    tick(2);
    n_cmp++; if (out_port !== 6'd0) begin n_err++; $display("FAIL wdog_out_held: got %b want 000000", out_port); end
    wr(2'd3, 32'h1);
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL wdog_clear: got %h want 0", readdata); end
    wr(2'd0, 32'h5);
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h5) begin n_err++; $display("FAIL wdog_cmd_accept: got %h want 5", readdata); end
    tick(1);
    n_cmp++; if (out_port !== 6'b001001) begin n_err++; $display("FAIL wdog_resume_out: got %b want 001001", out_port); end
  endtask

  task automatic test_simultaneous;
    int t;
    wr(2'd2, 32'h1);
    wr(2'd2, 32'h303);
    t = (cyc / PERIOD + 4) * PERIOD;
    wait_until(t - 1);
    wr(2'd0, 32'h5);
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL sim_trip_cmd: got %h want 0", readdata); end
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h1) begin n_err++; $display("FAIL sim_trip_status: got %h want 1", readdata); end
    wr(2'd3, 32'h1);
    #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL sim_clear: got %h want 0", readdata); end
    wait_until(t + PERIOD - 1);
    wr(2'd3, 32'h1);
    #1;
    n_cmp++; if (readdata !== 32'h1) begin n_err++; $display("FAIL sim_clear_vs_trip: got %h want 1", readdata); end
  endtask

  task automatic test_reset_mid_dead;
    wr(2'd2, 32'h1); wr(2'd3, 32'h1); wr(2'd1, 32'h0); wr(2'd0, 32'h5);
    tick(2);
    wr(2'd0, 32'h6);
    tick(10);
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h2) begin n_err++; $display("FAIL middead_status: got %h want 2", readdata); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_cmp++; if (out_port !== 6'd0) begin n_err++; $display("FAIL middead_out: got %b want 000000", out_port); end
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL middead_rd_status: got %h want 0", readdata); end
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL middead_rd_cmd: got %h want 0", readdata); end
    address = 2'd2; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL middead_rd_ctrl: got %h want 0", readdata); end
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_deadtime();
    test_coast_then_reverse();
    test_brake();
    test_watchdog();
    test_simultaneous();
    test_reset_mid_dead();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
